// File: rtl/load_wb_queue.sv
// In-order load destination queue: pairs each memory response with the oldest
// outstanding destination tag and drives the registered writeback triple.
module lwq_entry (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       clr,
  input  logic [6:0] din,
  input  logic [6:0] rs1,
  input  logic [6:0] rs2,
  output logic       occ,
  output logic [6:0] tag,
  output logic       hit
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= 1'b0;
      tag <= 7'h00;
    end else if (wr) begin
      occ <= 1'b1;
      tag <= din;
    end else if (clr) begin
      occ <= 1'b0;
    end
  end

  // Only the stored occupancy counts, so a same-cycle push is invisible here.
  assign hit = occ && ((rs1[6] && (rs1 == tag)) || (rs2[6] && (rs2 == tag)));
endmodule

module load_wb_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [6:0]    req_rd,
  output logic          req_ready,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          wb_mre,
  output logic [6:0]    wb_rd,
  output logic [31:0]   wb_memdata,
  input  logic [6:0]    hz_rs1,
  input  logic [6:0]    hz_rs2,
  output logic          hz_pending,
  output logic [CW-1:0] count,
  output logic          err_orphan
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] X0_TAG = 7'h40;

  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [DEPTH-1:0][6:0]     tags;
  logic [DEPTH-1:0]          occ, hit;
  logic                      push, pop, empty;
  logic [6:0]                head;

  assign empty     = (count == '0);
  assign req_ready = (count != CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = mem_rvalid && !empty;
  assign head      = tags[rd_ptr];
  assign hz_pending = |hit;

  // Push and pop never target the same slot: that needs count of 0 or DEPTH.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    lwq_entry u_ent (
      .clk (clk),
      .rst (rst),
      .wr  (push && (wr_ptr == AW'(i))),
      .clr (pop && (rd_ptr == AW'(i))),
      .din (req_rd),
      .rs1 (hz_rs1),
      .rs2 (hz_rs2),
      .occ (occ[i]),
      .tag (tags[i]),
      .hit (hit[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wb_mre     <= 1'b0;
      wb_rd      <= 7'h00;
      wb_memdata <= 32'h0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      wb_mre <= pop;
      if (pop) begin
        wb_rd      <= (head == X0_TAG) ? 7'h00 : head;
        wb_memdata <= mem_rdata;
      end
      if (mem_rvalid && empty) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_load_wb_queue.sv
// Directed bench for load_wb_queue: stimulus queues expected writebacks, an
// independent negedge monitor pops and compares them as wb_mre fires.
module tb_load_wb_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [6:0]  req_rd;
  logic        req_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_mre;
  logic [6:0]  wb_rd;
  logic [31:0] wb_memdata;
  logic [6:0]  hz_rs1, hz_rs2;
  logic        hz_pending;
  logic [2:0]  count;
  logic        err_orphan;

  int total = 0;
  int bad   = 0;
  logic [38:0] exp_q[$];

  always #5 clk = ~clk;

  load_wb_queue #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd),
    .req_ready(req_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_mre(wb_mre), .wb_rd(wb_rd), .wb_memdata(wb_memdata),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_pending(hz_pending),
    .count(count), .err_orphan(err_orphan)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one response in the current cycle and expect the given writeback.
  task automatic respond(input logic [6:0] rd, input logic [31:0] data);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    exp_q.push_back({rd, data});
    cyc();
    mem_rvalid = 1'b0;
  endtask

  task automatic push1(input logic [6:0] rd);
    req_valid = 1'b1;
    req_rd    = rd;
    cyc();
    req_valid = 1'b0;
  endtask

  // Monitor: every wb_mre cycle must match the oldest expected writeback.
  always @(negedge clk) begin
    if (!rst && wb_mre) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_rd), 32'hFFFF_FFFF);
      end else begin
        logic [38:0] e;
        e = exp_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e[38:32]));
        chk("wb_memdata", wb_memdata, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rd = 7'h00; mem_rvalid = 1'b0;
    mem_rdata = 32'h0; hz_rs1 = 7'h00; hz_rs2 = 7'h00;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_wb_mre", 32'(wb_mre), 0);
    chk("rst_orphan", 32'(err_orphan), 0);

    // single load, response three cycles after the push
    push1(7'h45);
    chk("single_count1", 32'(count), 1);
    cyc(); cyc();
    respond(7'h45, 32'hDEAD_BEEF);
    chk("single_wb_mre", 32'(wb_mre), 1);
    chk("single_count0", 32'(count), 0);
    cyc();
    chk("single_wb_mre_low", 32'(wb_mre), 0);
    chk("single_wb_rd_hold", 32'(wb_rd), 32'h45);
    chk("single_data_hold", wb_memdata, 32'hDEAD_BEEF);

    // fill, refused push, pop frees a slot, drain across the wrap
    for (int i = 1; i <= 4; i++) push1(7'(8'h40 + i));
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(req_ready), 0);
    req_valid = 1'b1; req_rd = 7'h46;
    cyc();
    chk("full_refused", 32'(count), 4);
    respond(7'h41, 32'h1);
    chk("full_pop_count", 32'(count), 3);
    chk("full_pop_ready", 32'(req_ready), 1);
    cyc();
    req_valid = 1'b0;
    chk("full_accept46", 32'(count), 4);
    respond(7'h42, 32'h2);
    respond(7'h43, 32'h3);
    respond(7'h44, 32'h4);
    respond(7'h46, 32'h5);
    chk("wrap_count0", 32'(count), 0);

    // simultaneous push and pop at count 2
    push1(7'h51);
    push1(7'h52);
    req_valid = 1'b1; req_rd = 7'h53;
    respond(7'h51, 32'hA1);
    req_valid = 1'b0;
    chk("simul_count", 32'(count), 2);
    respond(7'h52, 32'hA2);
    respond(7'h53, 32'hA3);
    chk("simul_count0", 32'(count), 0);

    // hazard detection
    push1(7'h63);
    hz_rs1 = 7'h63; #1;
    chk("hz_match_rs1", 32'(hz_pending), 1);
    hz_rs1 = 7'h43; #1;
    chk("hz_nomatch", 32'(hz_pending), 0);
    hz_rs1 = 7'h00; hz_rs2 = 7'h23; #1;
    chk("hz_invalid_rs2", 32'(hz_pending), 0);
    hz_rs2 = 7'h63; #1;
    chk("hz_match_rs2", 32'(hz_pending), 1);
    hz_rs2 = 7'h00; hz_rs1 = 7'h63; mem_rvalid = 1'b1; #1;
    chk("hz_popping_counts", 32'(hz_pending), 1);
    mem_rvalid = 1'b0;
    respond(7'h63, 32'hB0);
    req_valid = 1'b1; req_rd = 7'h64; hz_rs1 = 7'h64; #1;
    chk("hz_same_cycle_push", 32'(hz_pending), 0);
    cyc();
    req_valid = 1'b0; #1;
    chk("hz_after_push", 32'(hz_pending), 1);
    hz_rs1 = 7'h00;
    respond(7'h64, 32'hB1);

    // integer x0 writes back as tag 0
    push1(7'h40);
    respond(7'h00, 32'h1234_5678);
    cyc();

    // orphan response with empty queue
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    cyc();
    mem_rvalid = 1'b0;
    chk("orphan_flag", 32'(err_orphan), 1);
    chk("orphan_wb_mre", 32'(wb_mre), 0);
    chk("orphan_count", 32'(count), 0);
    // orphan alongside a push into an empty queue: new tag not consumed
    req_valid = 1'b1; req_rd = 7'h48; mem_rvalid = 1'b1;
    cyc();
    req_valid = 1'b0; mem_rvalid = 1'b0;
    chk("orphan_push_count", 32'(count), 1);
    chk("orphan_push_wb_mre", 32'(wb_mre), 0);
    respond(7'h48, 32'hC8);
    push1(7'h47);
    respond(7'h47, 32'hC7);
    chk("orphan_sticky", 32'(err_orphan), 1);
    cyc();

    // asynchronous reset mid-stream with two loads queued
    push1(7'h71);
    push1(7'h72);
    chk("pre_rst_count", 32'(count), 2);
    hz_rs1 = 7'h71;
    #2 rst = 1'b1;
    #1;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_wb_mre", 32'(wb_mre), 0);
    chk("mrst_wb_rd", 32'(wb_rd), 0);
    chk("mrst_wb_memdata", wb_memdata, 0);
    chk("mrst_orphan", 32'(err_orphan), 0);
    chk("mrst_ready", 32'(req_ready), 1);
    chk("mrst_hz", 32'(hz_pending), 0);
    cyc();
    rst = 1'b0; hz_rs1 = 7'h00;
    cyc(); cyc();
    chk("mrst_hold_count", 32'(count), 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
